// File: rtl/max10nios_response_arbiter_if.sv
// Bus bundle for max10nios_response_arbiter.
// Carries the Avalon-MM slave signals (CPU side) and the four-source
// response handshake (requester side).
//   address/chipselect/read/write_n/writedata : Avalon-MM command, from CPU
//   readdata/irq                               : Avalon-MM response and interrupt
//   req_valid/req_data                         : per-source byte offer, byte i on [8i+7:8i]
//   req_ready                                  : per-source accept, one-hot or zero
// The master modport is the side that drives commands and requests;
// the slave modport is the arbiter.
interface max10nios_response_arbiter_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;

  modport master (
    output address, chipselect, read, write_n, writedata, req_valid, req_data,
    input  readdata, irq, req_ready
  );

  modport slave (
    input  address, chipselect, read, write_n, writedata, req_valid, req_data,
    output readdata, irq, req_ready
  );
endinterface

// File: rtl/max10nios_response_arbiter.sv
// Round-robin arbiter plus 8-entry tagged FIFO sharing the Nios II
// response-input path between four response sources.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : slave side of max10nios_response_arbiter_if
//           (Avalon-MM register port, interrupt, source handshakes)
// Register map (word addresses):
//   0 DATA   read pops {1, 21'b0, src[1:0], byte[7:0]}, reads 0 when empty
//   1 STATUS [3:0] count, [4] empty, [5] full, [9:8] round-robin pointer
//   2 CTRL   [0] enable, [1] irq_en
//   3 CMD    write bit0 = 1 flushes the FIFO; reads 0
module max10nios_response_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 8
) (
  input logic                          clk,
  input logic                          reset,
  max10nios_response_arbiter_if.slave  bus
);

  localparam int         PTR_W    = $clog2(DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  // Control state
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [3:0]       count;
  logic [1:0]       rr_ptr;
  logic             enable;
  logic             irq_en;
  logic [31:0]      readdata_q;
  logic             irq_q;

  // Data storage: {src[1:0], byte[7:0]}, not reset
  logic [9:0]       mem [DEPTH];

  logic        rd_en;
  logic        wr_en;
  logic        flush;
  logic        ctrl_wr;
  logic        grant_ok;
  logic [3:0]  grant;
  logic [1:0]  gnt_idx;
  logic [1:0]  cand;
  logic        push;
  logic        pop;
  logic        empty;
  logic        full;
  logic [3:0]  count_next;
  logic [9:0]  head;
  logic [7:0]  push_byte;
  logic [31:0] status_word;
  logic [31:0] rd_mux;

  assign rd_en   = bus.chipselect & bus.read;
  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign flush   = wr_en & (bus.address == 2'd3) & bus.writedata[0];
  assign ctrl_wr = wr_en & (bus.address == 2'd2);

  assign empty = (count == 4'd0);
  assign full  = (count == FULL_CNT);

  // Grant is blocked at full even if a pop lands in the same cycle, so
  // the FIFO can never be written while full. Flush also suppresses it.
  assign grant_ok = ~reset & enable & ~full & ~flush;

  // Scan from rr_ptr upward; iterating from the far end lets the
  // candidate nearest to rr_ptr overwrite the others.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    cand    = '0;
    if (grant_ok) begin
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
        cand = rr_ptr + 2'(k);
        if (bus.req_valid[cand]) begin
          grant   = 4'b0001 << cand;
          gnt_idx = cand;
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign push          = |grant;
  assign push_byte     = bus.req_data[{gnt_idx, 3'b000} +: 8];

  assign pop = rd_en & (bus.address == 2'd0) & ~empty & ~flush;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = 4'd0;
    end else begin
      count_next = count + {3'b000, push} - {3'b000, pop};
    end
  end

  assign head        = mem[rd_ptr];
  assign status_word = {22'b0, rr_ptr, 2'b00, full, empty, count};

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux = pop ? {1'b1, 21'b0, head} : 32'd0;
      2'd1:    rd_mux = status_word;
      2'd2:    rd_mux = {30'b0, irq_en, enable};
      default: rd_mux = 32'd0;
    endcase
  end

  // Register stage: control, pointers, read data and interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rr_ptr     <= '0;
      enable     <= 1'b0;
      irq_en     <= 1'b0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      count <= count_next;
      irq_q <= irq_en & (count_next != 4'd0);

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end

      if (push) rr_ptr <= gnt_idx + 2'd1;

      if (ctrl_wr) begin
        enable <= bus.writedata[0];
        irq_en <= bus.writedata[1];
      end

      if (rd_en) readdata_q <= rd_mux;
    end
  end

  // Storage write, data path only
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {gnt_idx, push_byte};
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_max10nios_response_arbiter.sv
module tb_max10nios_response_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  max10nios_response_arbiter_if bus ();

  max10nios_response_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          vectors    = 0;
  int          miscompares = 0;
  logic [31:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = 32'd0;
  endtask

  task automatic avl_write(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    tick();
    clear_bus();
  endtask

  task automatic avl_read(input logic [1:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = a;
    tick();
    d = bus.readdata;
    clear_bus();
  endtask

  function automatic logic [31:0] tag(input int src, input logic [7:0] b);
    return {1'b1, 21'b0, 2'(src), b};
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    clear_bus();
    tick();
    tick();
    reset = 1'b0;
    bus.req_valid = 4'h0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    clear_bus();
    bus.req_valid = 4'hF;
    bus.req_data  = 32'h44332211;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
    end
    tick();
    tick();
    reset = 1'b0;
    bus.req_valid = 4'h0;
    vectors++;
    if (bus.readdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_readdata: got %h want 0", bus.readdata);
    end
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq: got %b want 0", bus.irq);
    end
    avl_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h0000_0010) begin
      miscompares++;
      $display("FAIL reset_status: got %h want 00000010", rd);
    end
    avl_read(2'd2, rd);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %h want 0", rd);
    end
  endtask

  task automatic test_single();
    logic [31:0] rd;
    logic [31:0] exp;
    avl_write(2'd2, 32'h1);
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h00A5_0000;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL single_ready: got %b want 0100", bus.req_ready);
    end
    tick();
    exp_q.push_back(tag(2, 8'hA5));
    bus.req_valid = 4'h0;
    avl_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h0000_0301) begin
      miscompares++;
      $display("FAIL single_status: got %h want 00000301", rd);
    end
    avl_read(2'd0, rd);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
    vectors++;
    if (rd !== exp || exp !== 32'h8000_02A5) begin
      miscompares++;
      $display("FAIL single_data: got %h want %h", rd, exp);
    end
    avl_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h0000_0310) begin
      miscompares++;
      $display("FAIL single_status_after: got %h want 00000310", rd);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] rd;
    logic [7:0]  b;
    apply_reset();
    avl_write(2'd2, 32'h1);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        b = {4'(k), 2'b00, 2'(i)};
        bus.req_data[8*i +: 8] = b;
      end
      bus.req_valid = 4'hF;
      @(negedge clk);
      vectors++;
      if (bus.req_ready !== (4'b0001 << (k % 4))) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got %b want %b", k, bus.req_ready, 4'b0001 << (k % 4));
      end
      exp_q.push_back(tag(k % 4, {4'(k), 2'b00, 2'(k % 4)}));
      tick();
    end
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL rr_full_ready: got %b want 0000", bus.req_ready);
    end
    avl_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h0000_0028) begin
      miscompares++;
      $display("FAIL rr_status: got %h want 00000028", rd);
    end
  endtask

  task automatic test_full_read();
    logic [31:0] rd;
    logic [31:0] exp;
    bus.req_valid = 4'hF;
    bus.req_data  = 32'h7372_7170;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = 2'd0;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL full_read_ready: got %b want 0000", bus.req_ready);
    end
    tick();
    clear_bus();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
    vectors++;
    if (bus.readdata !== exp) begin
      miscompares++;
      $display("FAIL full_read_data: got %h want %h", bus.readdata, exp);
    end
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL full_refill_ready: got %b want 0001", bus.req_ready);
    end
    exp_q.push_back(tag(0, 8'h70));
    tick();
    bus.req_valid = 4'h0;
    avl_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h0000_0128) begin
      miscompares++;
      $display("FAIL full_refill_status: got %h want 00000128", rd);
    end
    for (int n = 0; n < 8; n++) begin
      avl_read(2'd0, rd);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
      vectors++;
      if (rd !== exp) begin
        miscompares++;
        $display("FAIL drain%0d: got %h want %h", n, rd, exp);
      end
    end
    avl_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h0000_0110) begin
      miscompares++;
      $display("FAIL drain_status: got %h want 00000110", rd);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    logic [31:0] exp;
    logic [7:0]  b;
    int          s;
    for (int j = 0; j < 12; j++) begin
      s = j % 4;
      b = 8'hC0 + 8'(j);
      bus.req_data = 32'd0;
      bus.req_data[8*s +: 8] = b;
      bus.req_valid = 4'b0001 << s;
      if (j > 0) begin
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = 2'd0;
      end
      @(negedge clk);
      vectors++;
      if (bus.req_ready !== (4'b0001 << s)) begin
        miscompares++;
        $display("FAIL wrap_ready%0d: got %b want %b", j, bus.req_ready, 4'b0001 << s);
      end
      tick();
      clear_bus();
      if (j > 0) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
        vectors++;
        if (bus.readdata !== exp) begin
          miscompares++;
          $display("FAIL wrap_data%0d: got %h want %h", j, bus.readdata, exp);
        end
      end
      exp_q.push_back(tag(s, b));
    end
    bus.req_valid = 4'h0;
    avl_read(2'd0, rd);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
    vectors++;
    if (rd !== exp) begin
      miscompares++;
      $display("FAIL wrap_last: got %h want %h", rd, exp);
    end
    avl_read(2'd0, rd);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL empty_read: got %h want 00000000", rd);
    end
    avl_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h0000_0010) begin
      miscompares++;
      $display("FAIL empty_status: got %h want 00000010", rd);
    end
  endtask

  task automatic test_flush();
    logic [31:0] rd;
    avl_write(2'd2, 32'h3);
    for (int j = 0; j < 5; j++) begin
      bus.req_data  = 32'h0101_0101 * (j + 1);
      bus.req_valid = 4'b0001 << (j % 4);
      tick();
      exp_q.push_back(tag(j % 4, 8'(j + 1)));
    end
    bus.req_valid = 4'h0;
    vectors++;
    if (bus.irq !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_irq_before: got %b want 1", bus.irq);
    end
    avl_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h0000_0105) begin
      miscompares++;
      $display("FAIL flush_count5: got %h want 00000105", rd);
    end
    bus.req_valid  = 4'b0100;
    bus.req_data   = 32'h00EE_0000;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = 2'd3;
    bus.writedata  = 32'h1;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL flush_ready: got %b want 0000", bus.req_ready);
    end
    tick();
    clear_bus();
    bus.req_valid = 4'h0;
    exp_q.delete();
    vectors++;
    if (bus.readdata !== 32'd0) begin
      miscompares++;
      $display("FAIL flush_readdata: got %h want 0", bus.readdata);
    end
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_irq_after: got %b want 0", bus.irq);
    end
    avl_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h0000_0110) begin
      miscompares++;
      $display("FAIL flush_status: got %h want 00000110", rd);
    end
  endtask

  task automatic test_irq_reset();
    logic [31:0] rd;
    bus.req_data  = 32'h3322_1100;
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'h0;
    vectors++;
    if (bus.irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_set: got %b want 1", bus.irq);
    end
    bus.req_valid = 4'b1100;
    tick();
    tick();
    bus.req_valid = 4'h0;
    avl_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h0000_0003) begin
      miscompares++;
      $display("FAIL irq_count3: got %h want 00000003", rd);
    end
    reset = 1'b1;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL midreset_ready: got %b want 0000", bus.req_ready);
    end
    tick();
    reset = 1'b0;
    bus.req_valid = 4'h0;
    exp_q.delete();
    vectors++;
    if (bus.irq !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_irq: got %b want 0", bus.irq);
    end
    avl_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h0000_0010) begin
      miscompares++;
      $display("FAIL midreset_status: got %h want 00000010", rd);
    end
    avl_read(2'd2, rd);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset_ctrl: got %h want 0", rd);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 4'h0;
    bus.req_data  = 32'd0;
    clear_bus();
    test_reset();
    test_single();
    test_round_robin();
    test_full_read();
    test_wrap();
    test_flush();
    test_irq_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/max10nios_response_arbiter.md
# max10nios_response_arbiter

Round-robin arbiter and buffer that shares the Nios II response-input path between four external response sources. Each source hands over an 8-bit response byte with a valid/ready handshake. Granted bytes are tagged with their source ID and queued in an 8-entry FIFO. The CPU drains the FIFO through an Avalon-MM slave with registered read data and gets an optional not-empty interrupt.

## Interface
Parameters:
- NUM_SRC, 4, number of requesters (fixed at 4; source ID is 2 bits)
- DEPTH, 8, FIFO entries (power of two; count field is 4 bits)

Ports:
- clk  input  1  system clock; the block uses this single clock.
- reset  input  1  synchronous, active-high reset.
- address  input  2  Avalon-MM word address.
- chipselect  input  1  slave select.
- read  input  1  read strobe; qualified by chipselect.
- write_n  input  1  active-low write strobe; qualified by chipselect.
- writedata  input  32  write data.
- readdata  output  32  registered read data; read latency 1.
- irq  output  1  registered interrupt, level.
- req_valid  input  4  per-source byte valid.
- req_data  input  32  source i byte on bits [8i+7:8i].
- req_ready  output  4  per-source accept; combinational, one-hot or zero.

## Operation
Register map:
- Address 0, DATA, read: pops one entry.
  - Non-empty: readdata = {1'b1, 21'b0, src[1:0], data[7:0]}, i.e. bit 31 set, bits 9:8 source, bits 7:0 byte.
  - Empty: readdata = 0 and no pop.
  - Writes are ignored.
- Address 1, STATUS, read-only: [3:0] count (0..8), [4] empty, [5] full, [9:8] rr pointer, all other bits 0.
- Address 2, CTRL, read/write: bit0 enable, bit1 irq_en, all other bits read 0.
- Address 3, CMD, write-only: writing bit0 = 1 flushes the FIFO. Reads return 0.

Arbitration:
- A grant is possible only when enable = 1, count < DEPTH, and no flush is being written this cycle.
- The requester granted is the first i with req_valid[i] = 1, searching from ptr upward modulo 4.
- req_ready[i] = grant[i]. A transfer occurs when req_valid[i] and req_ready[i] are both 1.
- On a transfer from source i, push {i, req_data[8i+7:8i]} and set ptr = (i+1) mod 4. With no transfer, ptr holds.
- At most one push per cycle.

FIFO:
- Circular buffer with 3-bit read and write pointers; both wrap 7 to 0.
- A pop occurs on a DATA read with count > 0.
- Push and pop in the same cycle leave count unchanged and preserve order. Push-while-full cannot occur, because grant is blocked at count = 8 even if a pop happens the same cycle.
- Flush sets both pointers and count to 0. It wins over a simultaneous pop, which returns 0 data. No grant is issued that cycle.
- Clearing enable stops new grants; buffered entries remain readable.

Interrupt:
- irq is registered: irq <= irq_en & (count_next != 0).

Reset (synchronous, takes effect on the clk edge while reset = 1), aborting any operation in progress:
- readdata = 0, irq = 0, count = 0, FIFO pointers = 0, ptr = 0, enable = 0, irq_en = 0.
- req_ready = 0 while reset is asserted.
- FIFO storage contents are don't-care.

## Timing
- Requester handshake: combinational ready, single cycle. A byte accepted at edge N is reflected in STATUS.count from cycle N+1. A DATA read issued in cycle N+1 returns it in readdata in cycle N+2.
- Avalon reads: address sampled with read & chipselect at edge N; readdata valid after edge N, held until the next read.
- The pop takes effect at the same edge N, so back-to-back reads return consecutive entries.
- CTRL/CMD writes take effect at the sampling edge. A grant in the cycle of an enable write uses the old enable value.
- irq follows a push or pop with one cycle of latency.

## Test plan
- Reset then single source: enable = 1, source 2 presents 0xA5 for 1 cycle → req_ready = 4'b0100. STATUS = count 1, empty 0, ptr 3. DATA read returns 0x800002A5, and a following STATUS read shows count 0.
- Round-robin fairness: all four sources valid continuously from ptr = 0 → grants go 0, 1, 2, 3, 0, 1, 2, 3. FIFO then full, req_ready = 0, STATUS = 0x0000_0028 (count 8, full, ptr 0).
- Full with simultaneous read: FIFO full, DATA read while all sources are valid → no grant that cycle and count goes to 7. Next cycle, source 0 is granted and count returns to 8.
- Empty read and wrap: 12 push/pop pairs through the pointer wrap → data order preserved. A DATA read at count 0 returns 0x00000000 and count stays 0.
- Flush versus push/pop: count 5, CMD write 1 in the same cycle as a valid request and a DATA read → count 0, no req_ready, readdata 0, irq drops the next cycle.
- Interrupt and mid-operation reset: irq_en = 1, push one byte → irq = 1 one cycle later. Assert reset with count 3 → next cycle all status/CTRL fields read 0 and irq = 0.
